// File: rtl/pe_comp_ctrl_mlane.sv
// Multi-lane PE computation controller: pops {idx, value} activation packets and issues
// LANES-wide MAC commands per layer. Optional perf counters behind PE_COMP_PERF_CNT_EN.
module pe_comp_ctrl_mlane #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int ACT_NO_W = 10,
    parameter int LAYER_W  = 4,
    parameter int LANES    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               pe_idx,
    input  logic                     pe_start_calc,
    input  logic [LAYER_W-1:0]       layer_no,
    input  logic [ACT_NO_W-1:0]      out_act_no,
    input  logic                     comp_done,
    input  logic                     queue_empty,
    input  logic                     queue_empty_next,
    input  logic [ADDR_W+DATA_W-1:0] act_out,
    input  logic                     dp_ready,
    output logic                     pop_act,
    output logic                     pe_start_broadcast,
    output logic                     fin_comp,
    output logic                     all_done,
    output logic [LAYER_W-1:0]       layer_idx,
    output logic                     act_regfile_dir,
    output logic                     out_act_clear,
    output logic                     busy,
    output logic                     comp_en,
    output logic [LANES-1:0]         lane_mask,
    output logic [ACT_NO_W-1:0]      out_act_base,
    output logic [ADDR_W-1:0]        in_act_idx,
    output logic [DATA_W-1:0]        in_act_value
`ifdef PE_COMP_PERF_CNT_EN
    ,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int CW = ACT_NO_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DRAIN,
        ST_SYNC
    } state_t;

    state_t state, state_n;

    logic [ACT_NO_W-1:0] grp_base, grp_base_n;
    logic [ADDR_W-1:0]   head_idx;
    logic [DATA_W-1:0]   head_val;
    logic                head_marker, head_skip, no_out;
    logic [CW-1:0]       base_ext, cnt_ext;
    logic                last_grp;
    logic [LANES-1:0]    lane_mask_c;
    logic [LAYER_W-1:0]  last_layer;
    logic                issue, start_run, layer_adv, run_done, stall;

    assign {head_idx, head_val} = act_out;
    assign head_marker = (act_out == '0);
    assign head_skip   = (head_idx != '0) && (head_val == '0);
    assign no_out      = (out_act_no == '0);
    assign base_ext    = {1'b0, grp_base};
    assign cnt_ext     = {1'b0, out_act_no};
    assign last_grp    = (base_ext + CW'(LANES)) >= cnt_ext;
    assign last_layer  = (layer_no == '0) ? '0 : layer_no - LAYER_W'(1);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        lane_mask_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask_c[i] = (base_ext + CW'(i)) < cnt_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        grp_base_n = grp_base;
        pop_act    = 1'b0;
        fin_comp   = 1'b0;
        issue      = 1'b0;
        start_run  = 1'b0;
        layer_adv  = 1'b0;
        run_done   = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pe_start_calc) begin
                    start_run  = 1'b1;
                    grp_base_n = '0;
                    state_n    = ST_CALC;
                end
            end
            ST_CALC, ST_DRAIN: begin
                if (!queue_empty) begin
                    // Marker only ends the broadcast in CALC; in DRAIN it is consumed like a skip.
                    if (head_marker && state == ST_CALC) begin
                        pop_act = 1'b1;
                        if (queue_empty_next) begin
                            fin_comp = 1'b1;
                            state_n  = ST_SYNC;
                        end else begin
                            state_n  = ST_DRAIN;
                        end
                    end else if (head_marker || head_skip || no_out) begin
                        pop_act = 1'b1;
                        if (state == ST_DRAIN && queue_empty_next) begin
                            fin_comp = 1'b1;
                            state_n  = ST_SYNC;
                        end
                    end else if (dp_ready) begin
                        issue = 1'b1;
                        if (last_grp) begin
                            pop_act    = 1'b1;
                            grp_base_n = '0;
                            if (state == ST_DRAIN && queue_empty_next) begin
                                fin_comp = 1'b1;
                                state_n  = ST_SYNC;
                            end
                        end else begin
                            grp_base_n = grp_base + ACT_NO_W'(LANES);
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (comp_done) begin
                    if (layer_idx == last_layer) begin
                        run_done = 1'b1;
                        state_n  = ST_IDLE;
                    end else begin
                        layer_adv  = 1'b1;
                        grp_base_n = '0;
                        state_n    = ST_CALC;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_base           <= '0;
            layer_idx          <= '0;
            act_regfile_dir    <= 1'b0;
            pe_start_broadcast <= 1'b0;
            out_act_clear      <= 1'b0;
            all_done           <= 1'b0;
            comp_en            <= 1'b0;
            lane_mask          <= '0;
            out_act_base       <= '0;
            in_act_idx         <= '0;
            in_act_value       <= '0;
        end else begin
            grp_base           <= grp_base_n;
            pe_start_broadcast <= start_run || layer_adv;
            out_act_clear      <= start_run || layer_adv;
            all_done           <= run_done;
            if (start_run) begin
                layer_idx <= '0;
            end else if (layer_adv) begin
                layer_idx       <= layer_idx + LAYER_W'(1);
                act_regfile_dir <= ~act_regfile_dir;
            end
            comp_en      <= issue;
            lane_mask    <= issue ? lane_mask_c : '0;
            out_act_base <= issue ? grp_base : '0;
            in_act_idx   <= issue ? head_idx : '0;
            in_act_value <= issue ? head_val : '0;
        end
    end

`ifdef PE_COMP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start_run) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && pe_start_broadcast)
            $display("[pe %0d] layer %0d start", pe_idx, layer_idx);
    end
`endif

endmodule

// File: tb/tb_pe_comp_ctrl_mlane.sv
// Directed bench for pe_comp_ctrl_mlane: models the activation queue and scoreboards the
// expected MAC commands (base, mask, idx, value, pop alignment) in order.
module tb_pe_comp_ctrl_mlane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  pe_idx;
    logic        pe_start_calc;
    logic [3:0]  layer_no;
    logic [9:0]  out_act_no;
    logic        comp_done;
    logic        queue_empty;
    logic        queue_empty_next;
    logic [25:0] act_out;
    logic        dp_ready;
    logic        pop_act, pe_start_broadcast, fin_comp, all_done;
    logic [3:0]  layer_idx;
    logic        act_regfile_dir, out_act_clear, busy, comp_en;
    logic [3:0]  lane_mask;
    logic [9:0]  out_act_base;
    logic [9:0]  in_act_idx;
    logic [15:0] in_act_value;
`ifdef PE_COMP_PERF_CNT_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    pe_comp_ctrl_mlane #(
        .DATA_W(16), .ADDR_W(10), .ACT_NO_W(10), .LAYER_W(4), .LANES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pe_idx(pe_idx), .pe_start_calc(pe_start_calc),
        .layer_no(layer_no), .out_act_no(out_act_no), .comp_done(comp_done),
        .queue_empty(queue_empty), .queue_empty_next(queue_empty_next), .act_out(act_out),
        .dp_ready(dp_ready), .pop_act(pop_act), .pe_start_broadcast(pe_start_broadcast),
        .fin_comp(fin_comp), .all_done(all_done), .layer_idx(layer_idx),
        .act_regfile_dir(act_regfile_dir), .out_act_clear(out_act_clear), .busy(busy),
        .comp_en(comp_en), .lane_mask(lane_mask), .out_act_base(out_act_base),
        .in_act_idx(in_act_idx), .in_act_value(in_act_value)
`ifdef PE_COMP_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  base;
        logic [3:0]  mask;
        logic [9:0]  idx;
        logic [15:0] val;
        logic        pop;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [25:0] aq[$];

    int   tests = 0, fails = 0;
    int   pop_cnt = 0, fin_cnt = 0, fin_nopop = 0, cmd_cnt = 0;
    int   clr_cnt = 0, bc_cnt = 0, ad_cnt = 0;
    logic popped = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected commands for one entry with n output activations, 4 lanes.
    task automatic push_entry(input logic [9:0] idx, input logic [15:0] val, input int n);
        cmd_t e;
        for (int b = 0; b < n; b += 4) begin
            e.base = 10'(b);
            e.mask = '0;
            for (int i = 0; i < 4; i++) e.mask[i] = (b + i < n);
            e.idx  = idx;
            e.val  = val;
            e.pop  = (b + 4 >= n);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_q();
        act_out          = (aq.size() > 0) ? aq[0] : '0;
        queue_empty      = (aq.size() == 0);
        queue_empty_next = (aq.size() <= 1);
    endtask

    task automatic check_cmd();
        cmd_t e;
        if (comp_en) begin
            cmd_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_base", 64'(out_act_base), 64'(e.base));
                chk("cmd_mask", 64'(lane_mask), 64'(e.mask));
                chk("cmd_idx", 64'(in_act_idx), 64'(e.idx));
                chk("cmd_value", 64'(in_act_value), 64'(e.val));
                chk("cmd_pop_align", 64'(popped), 64'(e.pop));
            end
        end else begin
            chk("idle_fields_zero", 64'({lane_mask, out_act_base, in_act_idx, in_act_value}), 64'd0);
        end
    endtask

    // One clock: sample combinational outputs at negedge, registered ones 1 time unit after posedge.
    task automatic cycle();
        @(negedge clk);
        popped = pop_act;
        if (pop_act) pop_cnt++;
        if (fin_comp) begin
            fin_cnt++;
            if (!pop_act) fin_nopop++;
        end
        @(posedge clk);
        #1;
        if (popped && aq.size() > 0) void'(aq.pop_front());
        clr_cnt += int'(out_act_clear);
        bc_cnt  += int'(pe_start_broadcast);
        ad_cnt  += int'(all_done);
        check_cmd();
        drive_q();
    endtask

    task automatic run_until_fin(input int max_cyc, output int cyc);
        int start_fin;
        start_fin = fin_cnt;
        cyc = 0;
        while (fin_cnt == start_fin && cyc < max_cyc) begin
            cycle();
            cyc++;
        end
        chk("fin_timeout", 64'(fin_cnt != start_fin), 64'd1);
    endtask

    task automatic check_reset_state();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_layer_idx", 64'(layer_idx), 64'd0);
        chk("rst_dir", 64'(act_regfile_dir), 64'd0);
        chk("rst_comp_en", 64'(comp_en), 64'd0);
        chk("rst_pulses", 64'({pe_start_broadcast, out_act_clear, all_done}), 64'd0);
        chk("rst_cmd_fields", 64'({lane_mask, out_act_base, in_act_idx, in_act_value}), 64'd0);
        chk("rst_pop", 64'(pop_act), 64'd0);
        chk("rst_fin", 64'(fin_comp), 64'd0);
    endtask

    initial begin
        int cyc, p0, c0, clr0, bc0;
        rst_n = 1'b0; pe_idx = 6'd3; pe_start_calc = 1'b0; layer_no = 4'd2;
        out_act_no = 10'd10; comp_done = 1'b0; dp_ready = 1'b1;
        drive_q();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_state();
        rst_n = 1'b1;

        // Layer 0: real entry, zero-value skip, terminating marker.
        aq.push_back({10'd5, 16'h0003});
        aq.push_back({10'd7, 16'h0000});
        aq.push_back(26'd0);
        push_entry(10'd5, 16'h0003, 10);
        drive_q();
        pe_start_calc = 1'b1;
        cycle();
        pe_start_calc = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_clear", 64'(out_act_clear), 64'd1);
        chk("start_bcast", 64'(pe_start_broadcast), 64'd1);
        chk("start_layer", 64'(layer_idx), 64'd0);
        p0 = pop_cnt; c0 = cmd_cnt;
        run_until_fin(40, cyc);
        chk("l0_cycles", 64'(cyc), 64'd5);
        chk("l0_pops", 64'(pop_cnt - p0), 64'd3);
        chk("l0_cmds", 64'(cmd_cnt - c0), 64'd3);
        chk("l0_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("l0_clear_once", 64'(clr_cnt), 64'd1);
        cycle();
        chk("sync_hold_busy", 64'(busy), 64'd1);
        chk("sync_no_pop", 64'(popped), 64'd0);

        // Layer 1: back-pressure mid-entry, marker with trailing entry -> DRAIN.
        aq.push_back({10'd3, 16'h00AA});
        aq.push_back(26'd0);
        aq.push_back({10'd2, 16'h0055});
        push_entry(10'd3, 16'h00AA, 10);
        push_entry(10'd2, 16'h0055, 10);
        drive_q();
        comp_done = 1'b1;
        cycle();
        comp_done = 1'b0;
        chk("l1_layer_idx", 64'(layer_idx), 64'd1);
        chk("l1_dir", 64'(act_regfile_dir), 64'd1);
        chk("l1_clear", 64'(out_act_clear), 64'd1);
        chk("l1_bcast", 64'(pe_start_broadcast), 64'd1);
        cycle();
        chk("l1_clear_pulse_once", 64'(clr_cnt), 64'd2);
        chk("l1_bcast_pulse_once", 64'(bc_cnt), 64'd2);
        dp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin pe_start_calc = 1'b1; comp_done = 1'b1; end
            cycle();
            pe_start_calc = 1'b0; comp_done = 1'b0;
            chk("stall_no_pop", 64'(popped), 64'd0);
            chk("stall_no_cmd", 64'(comp_en), 64'd0);
        end
        chk("ignored_start_layer", 64'(layer_idx), 64'd1);
        chk("ignored_start_clear", 64'(clr_cnt), 64'd2);
        dp_ready = 1'b1;
        fin_nopop = 0;
        run_until_fin(40, cyc);
        chk("l1_cycles", 64'(cyc), 64'd6);
        chk("l1_queue_drained", 64'(aq.size()), 64'd0);
        chk("l1_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("fin_with_pop", 64'(fin_nopop), 64'd0);
        chk("fin_total", 64'(fin_cnt), 64'd2);
`ifdef PE_COMP_PERF_CNT_EN
        chk("perf_issue", 64'(perf_issue_cnt), 64'd9);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
`endif
        comp_done = 1'b1;
        cycle();
        comp_done = 1'b0;
        chk("all_done_pulse", 64'(all_done), 64'd1);
        chk("done_idle", 64'(busy), 64'd0);
        cycle();
        chk("all_done_once", 64'(ad_cnt), 64'd1);

        // Reset mid-CALC with out_act_no <= LANES.
        layer_no = 4'd1; out_act_no = 10'd3;
        aq.push_back({10'd1, 16'h0010});
        aq.push_back({10'd4, 16'h0020});
        aq.push_back(26'd0);
        push_entry(10'd1, 16'h0010, 3);
        push_entry(10'd4, 16'h0020, 3);
        drive_q();
        pe_start_calc = 1'b1;
        cycle();
        pe_start_calc = 1'b0;
        cycle();
        chk("small_n_one_cmd", 64'(exp_q.size()), 64'd1);
        rst_n = 1'b0;
        cycle();
        check_reset_state();
        rst_n = 1'b1;
        exp_q.delete();
        aq.delete();
        drive_q();

        // Restart: layer_no=0 acts as 1, out_act_no=0 pops entries without commands.
        layer_no = 4'd0; out_act_no = 10'd0;
        aq.push_back({10'd1, 16'h0010});
        aq.push_back(26'd0);
        drive_q();
        pe_start_calc = 1'b1;
        cycle();
        pe_start_calc = 1'b0;
        chk("restart_layer", 64'(layer_idx), 64'd0);
        chk("restart_bcast", 64'(pe_start_broadcast), 64'd1);
        c0 = cmd_cnt; clr0 = clr_cnt; bc0 = bc_cnt;
        run_until_fin(20, cyc);
        chk("zero_n_cycles", 64'(cyc), 64'd2);
        chk("zero_n_no_cmd", 64'(cmd_cnt - c0), 64'd0);
        comp_done = 1'b1;
        cycle();
        comp_done = 1'b0;
        chk("l0_only_all_done", 64'(all_done), 64'd1);
        chk("l0_only_idle", 64'(busy), 64'd0);
        chk("l0_only_no_extra_start", 64'((clr_cnt - clr0) + (bc_cnt - bc0)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
